// File: rtl/vga_vram_writer_if.sv
// Requester bundle for the VGA VRAM write-port controller.
// Carries the two write requesters' valid/address/data/ready signals.
//   master : a requester pair (drives valid/address/data, receives ready)
//   slave  : the controller (receives valid/address/data, drives ready)
interface vga_vram_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid;
  logic signed [31:0]    req0_address;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic signed [31:0]    req1_address;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  modport master (
    output req0_valid, req0_address, req0_data,
    output req1_valid, req1_address, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_address, req0_data,
    input  req1_valid, req1_address, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/vga_vram_writer.sv
// Write-port controller for the VGA VRAM and its scroll registers.
// Shares the single VRAM write port between two requesters (round-robin),
// runs a whole-VRAM fill engine, double-buffers the scroll offsets so they
// change only at vertical sync, and counts frames.
// Ports:
//   clk, reset (async, active low)
//   req         : requester bundle (slave side), readies are combinational
//   fill_start / fill_color / fill_busy : fill engine control
//   scroll_h_in / scroll_v_in / scroll_load : pending scroll offsets
//   vsync       : asynchronous vertical sync, active low
//   vram_address / vram_din / vram_we : registered VRAM write port
//   offset_h / offset_v : applied scroll offsets
//   frame_count : vsync falling edges seen (wraps)
//   addr_err    : sticky, an out-of-range request was dropped
module vga_vram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int VRAM_DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_vram_writer_if.slave      req,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  fill_busy,
  input  logic signed [31:0]    scroll_h_in,
  input  logic signed [31:0]    scroll_v_in,
  input  logic                  scroll_load,
  input  logic                  vsync,
  output logic [31:0]           vram_address,
  output logic [DATA_WIDTH-1:0] vram_din,
  output logic                  vram_we,
  output logic signed [31:0]    offset_h,
  output logic signed [31:0]    offset_v,
  output logic [15:0]           frame_count,
  output logic                  addr_err
);
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  // One extra bit so the counter can reach VRAM_DEPTH, which marks the
  // trailing busy cycle after the last write has been issued.
  localparam int CNT_W = $clog2(VRAM_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(VRAM_DEPTH);

  state_t                state, next_state;
  logic [CNT_W-1:0]      fill_cnt;
  logic [DATA_WIDTH-1:0] fill_col;
  logic                  fill_go, fill_own, fill_wr;
  logic [CNT_W-1:0]      fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  last1;
  logic                  grant0, grant1;
  logic signed [31:0]    sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  vs_s1, vs_s2, vs_s3, vs_fall;
  logic                  pend_valid;
  logic signed [31:0]    pend_h, pend_v;

  function automatic logic in_range(input logic signed [31:0] a);
    return (a >= 0) && (a < VRAM_DEPTH);
  endfunction

  // Fill FSM: state register plus address counter / colour capture.
  // The start cycle itself issues the write to address 0, so the counter
  // is cleared to the next address (1) when a fill is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      fill_col <= '0;
    end else begin
      state <= next_state;
      if (fill_go) begin
        fill_cnt <= CNT_W'(1);
        fill_col <= fill_color;
      end else if (fill_wr) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (fill_start) next_state = FILL;
      FILL: if (fill_cnt == DEPTH_C) next_state = IDLE;
    endcase
  end

  always_comb begin
    fill_busy = (state == FILL);
    fill_go   = (state == IDLE) && fill_start;
    fill_own  = fill_go || fill_busy;
    fill_wr   = fill_go || (fill_busy && (fill_cnt < DEPTH_C));
    fill_addr = fill_go ? '0 : fill_cnt;
    fill_data = fill_go ? fill_color : fill_col;
  end

  // Round-robin arbiter; last1 remembers which requester won last.
  // Readies are held low during reset so every output reads 0 then.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && !fill_own) begin
      if (req.req0_valid && (!req.req1_valid || last1)) grant0 = 1'b1;
      else if (req.req1_valid)                          grant1 = 1'b1;
    end
    sel_addr = grant1 ? req.req1_address : req.req0_address;
    sel_data = grant1 ? req.req1_data    : req.req0_data;
  end

  assign req.req0_ready = grant0;
  assign req.req1_ready = grant1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last1 <= 1'b1;
    end else if (grant0) begin
      last1 <= 1'b0;
    end else if (grant1) begin
      last1 <= 1'b1;
    end
  end

  // Registered write port; out-of-range requests are consumed silently
  // apart from raising the sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vram_we      <= 1'b0;
      vram_address <= '0;
      vram_din     <= '0;
      addr_err     <= 1'b0;
    end else begin
      vram_we <= 1'b0;
      if (fill_wr) begin
        vram_we      <= 1'b1;
        vram_address <= 32'(fill_addr);
        vram_din     <= fill_data;
      end else if (grant0 || grant1) begin
        if (in_range(sel_addr)) begin
          vram_we      <= 1'b1;
          vram_address <= sel_addr;
          vram_din     <= sel_data;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

  // vsync: two-flop synchronizer, a delayed copy, then a registered
  // falling-edge pulse three clocks after the pin falls. Flops start at 0
  // so a low vsync at reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_s3   <= 1'b0;
      vs_fall <= 1'b0;
    end else begin
      vs_s1   <= vsync;
      vs_s2   <= vs_s1;
      vs_s3   <= vs_s2;
      vs_fall <= vs_s3 && !vs_s2;
    end
  end

  // Scroll double-buffer and frame counter. A load coinciding with the
  // edge lands after the old pending value has been applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid  <= 1'b0;
      pend_h      <= '0;
      pend_v      <= '0;
      offset_h    <= '0;
      offset_v    <= '0;
      frame_count <= '0;
    end else begin
      if (vs_fall) begin
        frame_count <= frame_count + 16'd1;
        if (pend_valid) begin
          offset_h   <= pend_h;
          offset_v   <= pend_v;
          pend_valid <= 1'b0;
        end
      end
      if (scroll_load) begin
        pend_h     <= scroll_h_in;
        pend_v     <= scroll_v_in;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_vram_writer.sv
module tb_vga_vram_writer;
  localparam int DATA_WIDTH = 8;
  localparam int VRAM_DEPTH = 4096;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               fill_start = 1'b0;
  logic [7:0]         fill_color = '0;
  logic               fill_busy;
  logic signed [31:0] scroll_h_in = '0;
  logic signed [31:0] scroll_v_in = '0;
  logic               scroll_load = 1'b0;
  logic               vsync = 1'b1;
  logic [31:0]        vram_address;
  logic [7:0]         vram_din;
  logic               vram_we;
  logic signed [31:0] offset_h, offset_v;
  logic [15:0]        frame_count;
  logic               addr_err;

  vga_vram_writer_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  vga_vram_writer #(.DATA_WIDTH(DATA_WIDTH), .VRAM_DEPTH(VRAM_DEPTH)) dut (
    .clk(clk), .reset(reset), .req(bus),
    .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
    .scroll_h_in(scroll_h_in), .scroll_v_in(scroll_v_in), .scroll_load(scroll_load),
    .vsync(vsync), .vram_address(vram_address), .vram_din(vram_din), .vram_we(vram_we),
    .offset_h(offset_h), .offset_v(offset_v), .frame_count(frame_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t wq[$];        // expected VRAM writes, in order, tagged with their cycle
  int  fall_q[$];    // cycles in which the synchronized vsync edge is due

  // Reference model state
  bit model_on = 1'b0;
  int busy_until;
  bit m_last;        // 0: requester 0 won last, 1: requester 1 won last
  bit m_addr_err;
  bit pend_valid;
  int pend_h, pend_v, m_off_h, m_off_v, m_frame;
  bit g0 = 1'b0, g1 = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_until = -1;
    m_last = 1'b1;
    m_addr_err = 1'b0;
    pend_valid = 1'b0;
    pend_h = 0; pend_v = 0;
    m_off_h = 0; m_off_v = 0; m_frame = 0;
    g0 = 1'b0; g1 = 1'b0;
    fall_q.delete();
    wq.delete();
  endtask

  task automatic accept(input int a, input int d, input int n);
    if (a >= 0 && a < VRAM_DEPTH) wq.push_back('{n + 1, a, d});
    else m_addr_err = 1'b1;
  endtask

  // Per-cycle reference: compares visible state, then applies this cycle's events.
  task automatic model_step();
    int n;
    bit busy_e, start_ok, own, v0, v1, e0, e1;
    n = cyc;
    busy_e = (n <= busy_until);
    chk("fill_busy", fill_busy, busy_e);
    chk("addr_err", addr_err, m_addr_err);
    chk("offset_h", offset_h, m_off_h);
    chk("offset_v", offset_v, m_off_v);
    chk("frame_count", frame_count, m_frame);
    start_ok = fill_start && !busy_e;
    own = busy_e || start_ok;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    e0 = 1'b0; e1 = 1'b0;
    if (!own) begin
      if (v0 && v1) begin
        e0 = (m_last == 1'b1);
        e1 = (m_last == 1'b0);
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    g0 = e0; g1 = e1;
    if (start_ok) begin
      busy_until = n + VRAM_DEPTH;
      for (int i = 0; i < VRAM_DEPTH; i++) wq.push_back('{n + 1 + i, i, int'(fill_color)});
    end
    if (e0) begin m_last = 1'b0; accept(bus.req0_address, int'(bus.req0_data), n); end
    if (e1) begin m_last = 1'b1; accept(bus.req1_address, int'(bus.req1_data), n); end
    if (fall_q.size() > 0 && fall_q[0] == n) begin
      void'(fall_q.pop_front());
      m_frame = (m_frame + 1) % 65536;
      if (pend_valid) begin
        m_off_h = pend_h; m_off_v = pend_v; pend_valid = 1'b0;
      end
    end
    if (scroll_load) begin
      pend_h = scroll_h_in; pend_v = scroll_v_in; pend_valid = 1'b1;
    end
  endtask

  always @(negedge clk) if (model_on) model_step();

  // Scoreboard monitor: pops an expected write whenever the DUT writes.
  always @(negedge clk) begin
    wr_t w;
    if (vram_we) begin
      if (wq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: actual addr=%0d data=%0d required=no write cycle=%0d",
                 vram_address, vram_din, cyc);
      end else begin
        w = wq.pop_front();
        chk("write_cycle", cyc, w.cyc);
        chk("write_addr", vram_address, w.addr);
        chk("write_data", vram_din, w.data);
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      w = wq.pop_front();
      chk("write_we", vram_we, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_addr(input bit allow_bad);
    if (allow_bad && $urandom_range(0, 5) == 0) begin
      case ($urandom_range(0, 3))
        0: return VRAM_DEPTH;
        1: return -1;
        2: return VRAM_DEPTH + int'($urandom_range(1, 100000));
        default: return -int'($urandom_range(2, 100000));
      endcase
    end
    return int'($urandom_range(0, VRAM_DEPTH - 1));
  endfunction

  // Requesters hold a request until the model says it was granted.
  task automatic step_req(input int pct, input bit bad);
    if (!bus.req0_valid || g0) begin
      bus.req0_valid   = ($urandom_range(0, 99) < pct);
      bus.req0_address = pick_addr(bad);
      bus.req0_data    = 8'($urandom);
    end
    if (!bus.req1_valid || g1) begin
      bus.req1_valid   = ($urandom_range(0, 99) < pct);
      bus.req1_address = pick_addr(bad);
      bus.req1_data    = 8'($urandom);
    end
  endtask

  task automatic set_vsync(input bit v);
    if (vsync && !v) fall_q.push_back(cyc + 3);
    vsync = v;
  endtask

  task automatic inputs_idle();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_address = '0; bus.req1_address = '0;
    bus.req0_data = '0; bus.req1_data = '0;
    fill_start = 1'b0; scroll_load = 1'b0; vsync = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fill_busy"}, fill_busy, 0);
    chk({tag, "_vram_we"}, vram_we, 0);
    chk({tag, "_vram_address"}, vram_address, 0);
    chk({tag, "_vram_din"}, vram_din, 0);
    chk({tag, "_offset_h"}, offset_h, 0);
    chk({tag, "_offset_v"}, offset_v, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_addr_err"}, addr_err, 0);
    chk({tag, "_req0_ready"}, bus.req0_ready, 0);
    chk({tag, "_req1_ready"}, bus.req1_ready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    inputs_idle();
    // Reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.req0_valid = 1'($urandom); bus.req1_valid = 1'($urandom);
      bus.req0_address = int'($urandom_range(0, 5000)); bus.req1_address = -1;
      bus.req0_data = 8'($urandom); bus.req1_data = 8'($urandom);
      fill_start = 1'($urandom); fill_color = 8'($urandom);
      scroll_load = 1'($urandom); scroll_h_in = $urandom; scroll_v_in = $urandom;
      vsync = 1'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    tick();
    inputs_idle();
    repeat (3) tick();
    reset = 1'b1;
    model_reset();
    model_on = 1'b1;
    tick();

    // First request after reset, then one from requester 1
    bus.req0_valid = 1'b1; bus.req0_address = 5; bus.req0_data = 8'hA5;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_address = 7; bus.req1_data = 8'h3C;
    tick();
    bus.req1_valid = 1'b0;
    repeat (2) tick();

    // Both requesters continuously valid: alternating grants
    repeat (6) begin step_req(100, 1'b0); tick(); end
    repeat (4) begin step_req(0, 1'b0); tick(); end

    // Out-of-range addresses
    bus.req0_valid = 1'b1; bus.req0_address = VRAM_DEPTH; bus.req0_data = 8'h11;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_address = -1; bus.req1_data = 8'h22;
    tick();
    bus.req1_valid = 1'b0;
    repeat (3) tick();

    // Random traffic including bad addresses
    repeat (300) begin step_req(60, 1'b1); tick(); end
    repeat (4) begin step_req(0, 1'b0); tick(); end

    // Fill with a request pending on requester 1, and a restart attempt mid-fill
    bus.req1_valid = 1'b1; bus.req1_address = 100; bus.req1_data = 8'h77;
    fill_start = 1'b1; fill_color = 8'h1C;
    tick();
    fill_start = 1'b0;
    repeat (2000) begin step_req(0, 1'b0); tick(); end
    fill_start = 1'b1; fill_color = 8'hE3;
    tick();
    fill_start = 1'b0;
    repeat (2200) begin step_req(0, 1'b0); tick(); end

    // Fill under random traffic with random restart pulses
    fill_start = 1'b1; fill_color = 8'($urandom);
    tick();
    repeat (4150) begin
      step_req(50, 1'b1);
      fill_start = ($urandom_range(0, 500) == 0);
      fill_color = 8'($urandom);
      tick();
    end
    fill_start = 1'b0;
    repeat (4200) begin step_req(0, 1'b0); tick(); end

    // Scroll double-buffering
    scroll_h_in = 16; scroll_v_in = 32; scroll_load = 1'b1;
    tick();
    scroll_load = 1'b0;
    repeat (3) tick();
    set_vsync(1'b0); repeat (8) tick();
    set_vsync(1'b1); repeat (4) tick();
    set_vsync(1'b0); repeat (8) tick();
    set_vsync(1'b1); repeat (4) tick();

    // Load coinciding with the synchronized edge
    scroll_h_in = 8; scroll_v_in = 9; scroll_load = 1'b1;
    tick();
    scroll_load = 1'b0;
    tick();
    set_vsync(1'b0);
    repeat (3) tick();
    scroll_h_in = 48; scroll_v_in = 50; scroll_load = 1'b1;
    tick();
    scroll_load = 1'b0;
    repeat (4) tick();
    set_vsync(1'b1); repeat (4) tick();
    set_vsync(1'b0); repeat (8) tick();
    set_vsync(1'b1); repeat (4) tick();

    // Random scroll loads and vsync toggling alongside traffic
    repeat (400) begin
      step_req(30, 1'b1);
      scroll_load = ($urandom_range(0, 5) == 0);
      scroll_h_in = $urandom; scroll_v_in = $urandom;
      if ($urandom_range(0, 2) == 0) set_vsync(!vsync);
      tick();
    end
    scroll_load = 1'b0;
    set_vsync(1'b1);
    repeat (6) begin step_req(0, 1'b0); tick(); end

    // Frame counter wrap from 65535
    force dut.frame_count = 16'hFFFF;
    m_frame = 65535;
    tick();
    release dut.frame_count;
    repeat (2) tick();
    set_vsync(1'b0); repeat (6) tick();
    set_vsync(1'b1); repeat (4) tick();

    // Reset in the middle of a fill
    fill_start = 1'b1; fill_color = 8'h5A;
    tick();
    fill_start = 1'b0;
    repeat (50) tick();
    model_on = 1'b0;
    wq.delete();
    reset = 1'b0;
    #1;
    check_all_zero("midfill_reset");
    repeat (3) tick();
    inputs_idle();
    model_reset();
    reset = 1'b1;
    model_on = 1'b1;
    tick();
    bus.req0_valid = 1'b1; bus.req0_address = 9; bus.req0_data = 8'h99;
    tick();
    bus.req0_valid = 1'b0;
    repeat (5) tick();

    chk("write_queue_empty", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
